hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised successor hazard unit for the 5-stage RV32IM pipeline.
//  - Resolves forwarding (M over W), load-use stalls and branch flushes.
//  - Adds a per-register pending scoreboard for the multi-cycle mul/div unit,
//    so independent instructions keep flowing while a mul/div executes.
//  - Adds a stall watchdog. Sits beside the datapath and drives stage enables/flushes.
// PARAMETERS
//  NREG          32   architectural registers; x0 is hardwired zero
//  AW            5    register address width, $clog2(NREG)
//  STALL_TIMEOUT 64   consecutive stall cycles before hazard_err sets
// PORTS
//  clk          in   1   pipeline clock
//  rst_n        in   1   asynchronous active-low reset
//  raddr1D/2D   in   AW  source regs of instr in Decode
//  rdD          in   AW  dest reg of instr in Decode
//  reg_wrD      in   1   Decode instr writes rdD
//  md_opD       in   1   Decode instr is mul/div
//  raddr1E/2E   in   AW  source regs in Execute
//  waddrE/M/W   in   AW  dest regs in E/M/W
//  reg_wrE/M/W  in   1   write enables in E/M/W
//  wb_selE      in   2   E writeback select; 2'b10 = load
//  md_startE    in   1   mul/div issued from E this cycle (dest = waddrE)
//  md_done      in   1   mul/div result written to RF this cycle
//  md_waddr     in   AW  dest reg of completing mul/div
//  br_taken     in   1   branch/jump resolved taken in E
//  StallF/StallD out 1   hold PC / hold D register
//  FlushD/FlushE out 1   zero D / E pipeline register
//  forwardAE/BE out  2   00=from M, 10=from W, 01=register file
//  sb_pending   out  NREG  scoreboard bit per register (bit0 always 0)
//  md_busy      out  1   a mul/div is in flight
//  hazard_err   out  1   sticky watchdog flag
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - sb_pending=0, md_busy=0, stall counter=0, hazard_err=0.
//   - Comb outputs follow inputs; with pending=0 no scoreboard stall.
//  Forwarding, per operand:
//   - 00 if src!=0 & src==waddrM & reg_wrM.
//   - else 10 if src!=0 & src==waddrW & reg_wrW.
//   - else 01.
//  Stall causes (comb; any true -> sb_stall=1):
//   - load_use: wb_selE==2'b10 & reg_wrE & waddrE!=0 & waddrE in {raddr1D,raddr2D}.
//   - raw_md: sb_pending[raddr1D|raddr2D] set (addr!=0), or md_startE & waddrE!=0 & match.
//   - waw_md: reg_wrD & rdD!=0 & (sb_pending[rdD] | md_startE & waddrE==rdD).
//   - struct_md: md_opD & (md_busy | md_startE).
//  Stage control:
//   - sb_stall -> StallF=StallD=1, FlushE=1 (bubble into E).
//   - br_taken -> FlushD=FlushE=1, StallF=StallD=0; overrides sb_stall.
//  Scoreboard update (posedge clk):
//   - set  sb_pending[waddrE] on md_startE & waddrE!=0.
//   - clear sb_pending[md_waddr] on md_done.
//   - same reg set+clear in one cycle: set wins.
//   - Clear takes effect next cycle: D reader released the cycle after md_done,
//     reads RF.
//  md_busy: set on md_startE, cleared on md_done; both same cycle -> stays 1.
//   - md_startE with waddrE=0: md_busy still sets, no pending bit.
//  Watchdog:
//   - counter increments each cycle StallD=1, resets to 0 when StallD=0.
//   - reaching STALL_TIMEOUT sets hazard_err; saturates, hazard_err sticky until reset.
//  md_done with no matching pending bit: ignored, no error.
//  Reset mid-operation: all state cleared; in-flight mul/div owned by md unit reset.
// STRUCTURE
//  Shared pkg hazard_pkg:
//   - fwd_sel_e {FWD_M=2'b00, FWD_RF=2'b01, FWD_W=2'b10}
//   - WB_LOAD=2'b10
//   - hazard_ctrl_t {stallF, stallD, flushD, flushE}
//  Sub-module md_scoreboard:
//   - owns sb_pending, md_busy, set/clear logic.
//   - top holds forwarding, stall/flush priority, watchdog.
// TESTING
//  1 add x5 in M, sub reads x5 in E -> forwardAE=00; x5 only in W -> 10; x0 -> 01.
//  2 lw x6 in E, add x7,x6,x1 in D -> StallF=StallD=FlushE=1 one cycle, then 10 fwd.
//  3 mul x8 md_startE, then add x9,x8 in D -> stall until md_done(x8);
//    released next cycle; add x10,x1,x2 issued meanwhile not stalled.
//  4 mul in flight, div in D -> stall until md_done; div same cycle as md_done
//    still stalls one cycle.
//  5 br_taken during load-use stall -> FlushD=FlushE=1, StallF=0; counter resets.
//  6 hold md_done low 64 cycles with dependent in D -> hazard_err=1 at cycle 64,
//    stays 1; rst_n low clears all.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types for the hazard/scoreboard unit of the 5-stage RV32IM pipeline:
//   fwd_sel_e     - operand forwarding mux select
//   WB_LOAD       - writeback-select encoding that marks a load in Execute
//   hazard_ctrl_t - bundled stage stall/flush controls
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_M  = 2'b00,  // forward the Memory-stage result
    FWD_RF = 2'b01,  // no hazard, use the register-file read
    FWD_W  = 2'b10   // forward the Writeback-stage result
  } fwd_sel_e;

  localparam logic [1:0] WB_LOAD = 2'b10;

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic flushD;
    logic flushE;
  } hazard_ctrl_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit_if
// Bundle between the pipeline datapath (master) and the hazard unit (slave).
//   Decode  : raddr1D/raddr2D/rdD, reg_wrD, md_opD
//   Execute : raddr1E/raddr2E, waddrE, reg_wrE, wb_selE, md_startE, br_taken
//   Mem/WB  : waddrM/W, reg_wrM/W
//   mul/div : md_done, md_waddr
//   Outputs : StallF/StallD/FlushD/FlushE, forwardAE/BE, sb_pending, md_busy,
//             hazard_err
// -----------------------------------------------------------------------------
interface hazard_scoreboard_unit_if #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
);
  import hazard_pkg::*;

  logic [AW-1:0]   raddr1D, raddr2D, rdD;
  logic            reg_wrD, md_opD;
  logic [AW-1:0]   raddr1E, raddr2E;
  logic [AW-1:0]   waddrE, waddrM, waddrW;
  logic            reg_wrE, reg_wrM, reg_wrW;
  logic [1:0]      wb_selE;
  logic            md_startE, md_done;
  logic [AW-1:0]   md_waddr;
  logic            br_taken;

  logic            StallF, StallD, FlushD, FlushE;
  fwd_sel_e        forwardAE, forwardBE;
  logic [NREG-1:0] sb_pending;
  logic            md_busy;
  logic            hazard_err;

  // Datapath side: drives pipeline state, consumes the controls.
  modport master (
    output raddr1D, raddr2D, rdD, reg_wrD, md_opD,
    output raddr1E, raddr2E, waddrE, waddrM, waddrW,
    output reg_wrE, reg_wrM, reg_wrW, wb_selE,
    output md_startE, md_done, md_waddr, br_taken,
    input  StallF, StallD, FlushD, FlushE, forwardAE, forwardBE,
    input  sb_pending, md_busy, hazard_err
  );

  // Hazard unit side.
  modport slave (
    input  raddr1D, raddr2D, rdD, reg_wrD, md_opD,
    input  raddr1E, raddr2E, waddrE, waddrM, waddrW,
    input  reg_wrE, reg_wrM, reg_wrW, wb_selE,
    input  md_startE, md_done, md_waddr, br_taken,
    output StallF, StallD, FlushD, FlushE, forwardAE, forwardBE,
    output sb_pending, md_busy, hazard_err
  );

endinterface

// File: rtl/md_scoreboard.sv
// -----------------------------------------------------------------------------
// md_scoreboard
// Per-register pending bits for destinations of in-flight mul/div ops, plus
// the mul/div busy flag.
//   i_md_start  - mul/div issued this cycle, destination i_set_addr
//   i_md_done   - mul/div result written this cycle, destination i_clr_addr
//   o_pending   - one bit per architectural register (bit 0 never set)
//   o_md_busy   - a mul/div is in flight
// A set and a clear of the same register in one cycle leaves it set.
// -----------------------------------------------------------------------------
module md_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_md_start,
  input  logic [AW-1:0]   i_set_addr,
  input  logic            i_md_done,
  input  logic [AW-1:0]   i_clr_addr,
  output logic [NREG-1:0] o_pending,
  output logic            o_md_busy
);

  localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);

  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] r_pending;
  logic            r_md_busy;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_md_start && (i_set_addr != '0)) w_set_mask = ONE_HOT0 << i_set_addr;
    if (i_md_done)                        w_clr_mask = ONE_HOT0 << i_clr_addr;
  end

  // NOTE: the pending vector is control state, not data storage, so it is
  // reset like any other flop; a stale bit would stall the pipeline forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_md_busy <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      // Clear first, then OR in the set mask: set wins on a collision.
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
      if (i_md_start)     r_md_busy <= 1'b1;
      else if (i_md_done) r_md_busy <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_md_busy = r_md_busy;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
// Hazard unit for the 5-stage RV32IM pipeline: operand forwarding (M over W),
// load-use and mul/div scoreboard stalls, branch flushes and a stall watchdog.
//   clk, rst_n - pipeline clock, asynchronous active-low reset
//   bus        - slave side of hazard_scoreboard_unit_if (see that file)
// Stage controls and forwarding are combinational; sb_pending, md_busy and
// hazard_err are registered.
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NREG          = 32,
  parameter int AW            = $clog2(NREG),
  parameter int STALL_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  hazard_scoreboard_unit_if.slave   bus
);

  localparam int            CW      = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT = CW'(STALL_TIMEOUT);

  logic [NREG-1:0] w_pending;
  logic            w_md_busy;
  logic            w_load_use, w_raw_md, w_waw_md, w_struct_md, w_sb_stall;
  hazard_ctrl_t    w_ctrl;
  logic [CW-1:0]   r_stall_cnt;
  logic            r_hazard_err;

  md_scoreboard #(.NREG(NREG), .AW(AW)) u_md_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_md_start (bus.md_startE),
    .i_set_addr (bus.waddrE),
    .i_md_done  (bus.md_done),
    .i_clr_addr (bus.md_waddr),
    .o_pending  (w_pending),
    .o_md_busy  (w_md_busy)
  );

  // Memory stage has the younger result, so it is checked before Writeback.
  function automatic fwd_sel_e fwd_select(input logic [AW-1:0] src,
                                          input logic [AW-1:0] wa_m,
                                          input logic          we_m,
                                          input logic [AW-1:0] wa_w,
                                          input logic          we_w);
    if ((src != '0) && (src == wa_m) && we_m)      return FWD_M;
    else if ((src != '0) && (src == wa_w) && we_w) return FWD_W;
    else                                           return FWD_RF;
  endfunction

  // A register is "busy" for Decode when its pending bit is set or when the
  // mul/div targeting it is being issued from Execute right now.
  function automatic logic md_owns(input logic [AW-1:0] r,
                                   input logic [NREG-1:0] pend,
                                   input logic start,
                                   input logic [AW-1:0] wa_e);
    return (r != '0) && (pend[r] || (start && (wa_e == r)));
  endfunction

  always_comb begin
    w_load_use  = (bus.wb_selE == WB_LOAD) && bus.reg_wrE && (bus.waddrE != '0) &&
                  ((bus.waddrE == bus.raddr1D) || (bus.waddrE == bus.raddr2D));
    w_raw_md    = md_owns(bus.raddr1D, w_pending, bus.md_startE, bus.waddrE) ||
                  md_owns(bus.raddr2D, w_pending, bus.md_startE, bus.waddrE);
    w_waw_md    = bus.reg_wrD && md_owns(bus.rdD, w_pending, bus.md_startE, bus.waddrE);
    w_struct_md = bus.md_opD && (w_md_busy || bus.md_startE);
    w_sb_stall  = w_load_use || w_raw_md || w_waw_md || w_struct_md;

    w_ctrl = '0;
    if (bus.br_taken) begin
      // The instructions in D/E are on the wrong path; holding them would be
      // pointless, so a taken branch overrides any stall.
      w_ctrl.flushD = 1'b1;
      w_ctrl.flushE = 1'b1;
    end else if (w_sb_stall) begin
      w_ctrl.stallF = 1'b1;
      w_ctrl.stallD = 1'b1;
      w_ctrl.flushE = 1'b1;
    end
  end

  // Watchdog: counts consecutive Decode stalls and saturates at the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_hazard_err <= 1'b0;
    end else if (w_ctrl.stallD) begin
      if (r_stall_cnt != TIMEOUT)           r_stall_cnt  <= r_stall_cnt + 1'b1;
      if (r_stall_cnt >= TIMEOUT - 1'b1)    r_hazard_err <= 1'b1;
    end else begin
      r_stall_cnt <= '0;
    end
  end

  assign bus.StallF     = w_ctrl.stallF;
  assign bus.StallD     = w_ctrl.stallD;
  assign bus.FlushD     = w_ctrl.flushD;
  assign bus.FlushE     = w_ctrl.flushE;
  assign bus.forwardAE  = fwd_select(bus.raddr1E, bus.waddrM, bus.reg_wrM,
                                     bus.waddrW, bus.reg_wrW);
  assign bus.forwardBE  = fwd_select(bus.raddr2E, bus.waddrM, bus.reg_wrM,
                                     bus.waddrW, bus.reg_wrW);
  assign bus.sb_pending = w_pending;
  assign bus.md_busy    = w_md_busy;
  assign bus.hazard_err = r_hazard_err;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard_unit
// Directed pipeline scenarios followed by randomized traffic, every cycle
// compared against a reference model that keeps outstanding mul/div
// destinations as a queue of register numbers.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int TO   = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.NREG(NREG), .AW(AW)) bus ();

  hazard_scoreboard_unit #(.NREG(NREG), .AW(AW), .STALL_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_q[$];       // registers with an outstanding mul/div result
  bit m_busy;
  int m_cnt;
  bit m_err;
  bit m_stall_d;    // expected StallD of the current cycle

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_pend(input int r);
    foreach (m_q[i]) if (m_q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    v = '0;
    foreach (m_q[i]) v[m_q[i]] = 1'b1;
    return v;
  endfunction

  function automatic logic [1:0] exp_fwd(input int src);
    if (src != 0 && src == int'(bus.waddrM) && bus.reg_wrM) return 2'b00;
    if (src != 0 && src == int'(bus.waddrW) && bus.reg_wrW) return 2'b10;
    return 2'b01;
  endfunction

  function automatic bit md_target(input int r);
    return r != 0 && (is_pend(r) || (bus.md_startE && int'(bus.waddrE) == r));
  endfunction

  function automatic bit exp_stall();
    int d1, d2, we;
    bit lu, raw, waw, st;
    d1 = bus.raddr1D; d2 = bus.raddr2D; we = bus.waddrE;
    lu  = bus.wb_selE == 2'b10 && bus.reg_wrE && we != 0 && (we == d1 || we == d2);
    raw = md_target(d1) || md_target(d2);
    waw = bus.reg_wrD && md_target(int'(bus.rdD));
    st  = bus.md_opD && (m_busy || bus.md_startE);
    return lu || raw || waw || st;
  endfunction

  task automatic idle();
    bus.raddr1D = '0; bus.raddr2D = '0; bus.rdD = '0;
    bus.reg_wrD = 1'b0; bus.md_opD = 1'b0;
    bus.raddr1E = '0; bus.raddr2E = '0;
    bus.waddrE = '0; bus.waddrM = '0; bus.waddrW = '0;
    bus.reg_wrE = 1'b0; bus.reg_wrM = 1'b0; bus.reg_wrW = 1'b0;
    bus.wb_selE = 2'b00; bus.md_startE = 1'b0; bus.md_done = 1'b0;
    bus.md_waddr = '0; bus.br_taken = 1'b0;
  endtask

  // Settle the combinational outputs and compare everything with the model.
  task automatic eval();
    bit s, b;
    #1;
    s = exp_stall();
    b = bus.br_taken;
    m_stall_d = !b && s;
    check("StallF",     bus.StallF,     !b && s);
    check("StallD",     bus.StallD,     !b && s);
    check("FlushD",     bus.FlushD,     b);
    check("FlushE",     bus.FlushE,     b || s);
    check("forwardAE",  bus.forwardAE,  exp_fwd(int'(bus.raddr1E)));
    check("forwardBE",  bus.forwardBE,  exp_fwd(int'(bus.raddr2E)));
    check("sb_pending", bus.sb_pending, pend_vec());
    check("md_busy",    bus.md_busy,    m_busy);
    check("hazard_err", bus.hazard_err, m_err);
  endtask

  // Clock edge: advance the model with the inputs that were just evaluated.
  task automatic tick();
    int wa, da;
    @(posedge clk);
    wa = bus.waddrE;
    da = bus.md_waddr;
    if (bus.md_done)
      foreach (m_q[i]) if (m_q[i] == da) begin m_q.delete(i); break; end
    if (bus.md_startE && wa != 0 && !is_pend(wa)) m_q.push_back(wa);
    if (bus.md_startE)     m_busy = 1'b1;
    else if (bus.md_done)  m_busy = 1'b0;
    if (m_stall_d) begin
      if (m_cnt < TO) m_cnt++;
      if (m_cnt >= TO) m_err = 1'b1;
    end else begin
      m_cnt = 0;
    end
    #1;
  endtask

  task automatic step();
    eval();
    tick();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    check("rst_pending", bus.sb_pending, 32'h0);
    check("rst_busy",    bus.md_busy,    1'b0);
    check("rst_err",     bus.hazard_err, 1'b0);
    m_q.delete(); m_busy = 1'b0; m_cnt = 0; m_err = 1'b0; m_stall_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    do_reset();
    step();

    // 1: forwarding priority M over W, x0 never forwarded.
    idle(); bus.raddr1E = 5; bus.waddrM = 5; bus.reg_wrM = 1'b1;
    bus.raddr2E = 5; bus.waddrW = 5; bus.reg_wrW = 1'b1;
    eval(); check("t1_fwdA_M", bus.forwardAE, 2'b00); check("t1_fwdB_M", bus.forwardBE, 2'b00); tick();
    bus.reg_wrM = 1'b0;
    eval(); check("t1_fwdA_W", bus.forwardAE, 2'b10); tick();
    idle(); bus.waddrM = 0; bus.reg_wrM = 1'b1;
    eval(); check("t1_fwdA_x0", bus.forwardAE, 2'b01); tick();

    // 2: load-use stall for one cycle, then forward from W.
    idle(); bus.wb_selE = 2'b10; bus.reg_wrE = 1'b1; bus.waddrE = 6;
    bus.raddr1D = 6; bus.raddr2D = 1; bus.rdD = 7; bus.reg_wrD = 1'b1;
    eval(); check("t2_stallD", bus.StallD, 1'b1); check("t2_flushE", bus.FlushE, 1'b1); tick();
    idle(); bus.raddr1E = 6; bus.raddr2E = 1; bus.waddrW = 6; bus.reg_wrW = 1'b1;
    eval(); check("t2_fwdW", bus.forwardAE, 2'b10); check("t2_nostall", bus.StallD, 1'b0); tick();

    // 3: dependent on mul stalls until md_done, released the next cycle.
    idle(); bus.md_startE = 1'b1; bus.waddrE = 8; bus.reg_wrE = 1'b1; bus.raddr1D = 8;
    bus.rdD = 9; bus.reg_wrD = 1'b1;
    eval(); check("t3_stall_issue", bus.StallD, 1'b1); tick();
    idle(); bus.raddr1D = 8; bus.rdD = 9; bus.reg_wrD = 1'b1;
    for (int i = 0; i < 3; i++) step();
    idle(); bus.raddr1D = 1; bus.raddr2D = 2; bus.rdD = 10; bus.reg_wrD = 1'b1;
    eval(); check("t3_indep", bus.StallD, 1'b0); tick();
    idle(); bus.raddr2D = 8; bus.rdD = 9; bus.reg_wrD = 1'b1; bus.md_done = 1'b1; bus.md_waddr = 8;
    eval(); check("t3_done_stall", bus.StallD, 1'b1); tick();
    bus.md_done = 1'b0;
    eval(); check("t3_release", bus.StallD, 1'b0); check("t3_pend", bus.sb_pending, 32'h0); tick();

    // 4: structural stall of a second mul/div, including the md_done cycle.
    idle(); bus.md_startE = 1'b1; bus.waddrE = 11; bus.reg_wrE = 1'b1;
    step();
    idle(); bus.md_opD = 1'b1; bus.raddr1D = 3; bus.raddr2D = 4; bus.rdD = 12; bus.reg_wrD = 1'b1;
    step(); step();
    bus.md_done = 1'b1; bus.md_waddr = 11;
    eval(); check("t4_done_stall", bus.StallD, 1'b1); tick();
    bus.md_done = 1'b0;
    eval(); check("t4_release", bus.StallD, 1'b0); check("t4_busy", bus.md_busy, 1'b0); tick();

    // 5: taken branch overrides a load-use stall.
    idle(); bus.wb_selE = 2'b10; bus.reg_wrE = 1'b1; bus.waddrE = 6; bus.raddr2D = 6;
    step(); step();
    bus.br_taken = 1'b1;
    eval();
    check("t5_flushD", bus.FlushD, 1'b1); check("t5_flushE", bus.FlushE, 1'b1);
    check("t5_stallF", bus.StallF, 1'b0); check("t5_stallD", bus.StallD, 1'b0);
    tick();

    // 7: start to x0 sets busy only; stray md_done ignored; set wins on collision.
    idle(); bus.md_startE = 1'b1; bus.waddrE = 0;
    step();
    check("t7_busy_x0", bus.md_busy, 1'b1); check("t7_pend_x0", bus.sb_pending, 32'h0);
    idle(); bus.md_done = 1'b1; bus.md_waddr = 20;
    step();
    check("t7_stray_done", bus.sb_pending, 32'h0);
    idle(); bus.md_startE = 1'b1; bus.waddrE = 9; step();
    bus.md_done = 1'b1; bus.md_waddr = 9; step();
    check("t7_set_wins", bus.sb_pending, 32'h0000_0200); check("t7_busy_both", bus.md_busy, 1'b1);
    idle(); bus.md_done = 1'b1; bus.md_waddr = 9; step();
    idle(); step();

    // 6: watchdog trips after 64 consecutive stalled cycles and is sticky.
    idle(); bus.md_startE = 1'b1; bus.waddrE = 13; bus.reg_wrE = 1'b1; bus.raddr1D = 13;
    for (int k = 1; k <= 68; k++) begin
      step();
      if (k == 1) begin idle(); bus.raddr1D = 13; end
      if (k == 63) check("t6_err_63", bus.hazard_err, 1'b0);
      if (k == 64) check("t6_err_64", bus.hazard_err, 1'b1);
    end
    idle(); bus.raddr1D = 13; bus.md_done = 1'b1; bus.md_waddr = 13; step();
    idle(); step(); step();
    check("t6_sticky", bus.hazard_err, 1'b1);
    #2;
    do_reset();

    // Randomized traffic over a small register window to provoke hazards.
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        bus.raddr1D   = AW'($urandom_range(0, 7));
        bus.raddr2D   = AW'($urandom_range(0, 7));
        bus.rdD       = AW'($urandom_range(0, 7));
        bus.reg_wrD   = 1'($urandom_range(0, 1));
        bus.md_opD    = ($urandom_range(0, 3) == 0);
        bus.raddr1E   = AW'($urandom_range(0, 7));
        bus.raddr2E   = AW'($urandom_range(0, 7));
        bus.waddrE    = AW'($urandom_range(0, 7));
        bus.waddrM    = AW'($urandom_range(0, 7));
        bus.waddrW    = AW'($urandom_range(0, 7));
        bus.reg_wrE   = 1'($urandom_range(0, 1));
        bus.reg_wrM   = 1'($urandom_range(0, 1));
        bus.reg_wrW   = 1'($urandom_range(0, 1));
        bus.wb_selE   = 2'($urandom_range(0, 3));
        bus.md_startE = ($urandom_range(0, 5) == 0);
        bus.br_taken  = ($urandom_range(0, 9) == 0);
        bus.md_done   = 1'b0;
        bus.md_waddr  = AW'($urandom_range(0, 7));
        if (m_busy && $urandom_range(0, 2) == 0) begin
          bus.md_done = 1'b1;
          if (m_q.size() > 0) bus.md_waddr = AW'(m_q[$urandom_range(0, m_q.size() - 1)]);
        end else if ($urandom_range(0, 19) == 0) begin
          bus.md_done = 1'b1;
        end
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
